data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 23 ++
 rtl/data_ram_array.sv | 31 +++
 rtl/data_ram.sv | 129 ++++++++++++
 tb/tb_data_ram.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM: bus widths, default depth, FSM states
// and the latched request record.
package data_ram_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned SEL_W         = DATA_W / 8;
    localparam int unsigned MEM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W-3:0]     waddr;
        logic [DATA_W-1:0]     data;
        logic [SEL_W-1:0]      sel;
    } req_t;

endpackage

// File: rtl/data_ram_array.sv
// Word storage with byte-lane writes and asynchronous read; contents are
// intentionally not reset.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_WORDS_DEF,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                if (sel_i[k]) begin
                    mem_q[idx_i][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    assign data_o = mem_q[idx_i];

endmodule

// File: rtl/data_ram.sv
// Multi-cycle data RAM for the CPU mem stage: stalls the pipeline for
// WAIT_CYCLES per access, flags out-of-range addresses, aborts when ce_i drops.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_WORDS   = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stallreq_o,
    output logic              err_o
);

    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    req_t       req_q, req_d;

    logic              oor_cur, oor_lat;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] data_c;
    logic              stall_c, err_c;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];
    assign oor_cur = |addr_i[ADDR_W-1:IDX_W+2];
    assign oor_lat = |req_q.waddr[ADDR_W-3:IDX_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        stall_c   = 1'b0;
        err_c     = 1'b0;
        data_c    = '0;
        mem_we    = 1'b0;
        mem_idx   = req_q.waddr[IDX_W-1:0];
        mem_wdata = req_q.data;
        mem_sel   = req_q.sel;
        if (WAIT_CYCLES == 0) begin
            // Zero-wait mode bypasses the FSM and serves the live request.
            mem_idx   = addr_i[IDX_W+1:2];
            mem_wdata = data_i;
            mem_sel   = sel_i;
            err_c     = ce_i && oor_cur;
            if (ce_i && !oor_cur) begin
                if (we_i) mem_we = 1'b1;
                else      data_c = mem_rdata;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ce_i) begin
                        stall_c = 1'b1;
                        req_d   = '{we: we_i, waddr: addr_i[ADDR_W-1:2],
                                    data: data_i, sel: sel_i};
                        cnt_d   = 4'd1;
                        state_d = (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Only ce_i is observed while waiting; its loss aborts the access.
                    if (!ce_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        stall_c = 1'b1;
                        if (cnt_q == LAST_CNT) state_d = ST_DONE;
                        else                   cnt_d   = cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    err_c   = oor_lat;
                    if (!oor_lat) begin
                        if (req_q.we) mem_we = 1'b1;
                        else          data_c = mem_rdata;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    data_ram_array #(
        .DEPTH (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we && rst),
        .sel_i  (mem_sel),
        .idx_i  (mem_idx),
        .data_i (mem_wdata),
        .data_o (mem_rdata)
    );

    assign data_o     = rst ? data_c  : '0;
    assign stallreq_o = rst ? stall_c : 1'b0;
    assign err_o      = rst ? err_c   : 1'b0;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: three instances (WAIT_CYCLES 2, 3 and 0)
// driven with directed vectors; a negedge monitor checks queued expectations.
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic        ce   [3];
    logic        we   [3];
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [3:0]  sel  [3];
    logic [31:0] dout [3];
    logic        stall[3];
    logic        err  [3];

    typedef struct {
        int          d;
        logic        stall;
        logic [31:0] data;
        logic        err;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    data_ram #(.WAIT_CYCLES(2), .MEM_WORDS(1024)) u_w2 (
        .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
        .data_i(wdat[0]), .sel_i(sel[0]), .data_o(dout[0]),
        .stallreq_o(stall[0]), .err_o(err[0]));

    data_ram #(.WAIT_CYCLES(3), .MEM_WORDS(1024)) u_w3 (
        .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
        .data_i(wdat[1]), .sel_i(sel[1]), .data_o(dout[1]),
        .stallreq_o(stall[1]), .err_o(err[1]));

    data_ram #(.WAIT_CYCLES(0), .MEM_WORDS(1024)) u_w0 (
        .clk(clk), .rst(rst), .ce_i(ce[2]), .we_i(we[2]), .addr_i(addr[2]),
        .data_i(wdat[2]), .sel_i(sel[2]), .data_o(dout[2]),
        .stallreq_o(stall[2]), .err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (stall[e.d] !== e.stall || dout[e.d] !== e.data || err[e.d] !== e.err) begin
                errors++;
                $display("FAIL %s (dut%0d): got stall=%b data=%h err=%b, expected stall=%b data=%h err=%b",
                         e.nm, e.d, stall[e.d], dout[e.d], err[e.d], e.stall, e.data, e.err);
            end
        end
    end

    task automatic expect_out(input int d, input logic es, input logic [31:0] ed,
                              input logic ee, input string nm);
        exp_t e;
        e.d = d; e.stall = es; e.data = ed; e.err = ee; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic drive(input int d, input logic c, input logic w,
                         input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s);
        ce[d] = c; we[d] = w; addr[d] = a; wdat[d] = dt; sel[d] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int d, input logic c, input logic w,
                        input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s,
                        input logic es, input logic [31:0] ed, input logic ee,
                        input string nm);
        drive(d, c, w, a, dt, s);
        expect_out(d, es, ed, ee, nm);
        tick();
    endtask

    // Full FSM access with ce_i held through the wait cycles and dropped in DONE.
    task automatic access(input int d, input int w_cyc, input logic w,
                          input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s,
                          input logic [31:0] ed, input logic ee, input string nm);
        for (int i = 0; i < w_cyc; i++)
            step(d, 1'b1, w, a, dt, s, 1'b1, 32'h0, 1'b0, {nm, "_stall"});
        step(d, 1'b0, w, a, dt, s, 1'b0, ed, ee, {nm, "_done"});
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Requests during reset must produce no outputs.
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
            expect_out(i, 1'b0, 32'h0, 1'b0, "reset_outputs");
        end
        tick();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) expect_out(i, 1'b0, 32'h0, 1'b0, "idle_after_reset");
        tick();

        // W=2 full-word write then read back.
        access(0, 2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "w2_write10");
        step(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "w2_idle");
        access(0, 2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "w2_read10");

        // Byte-lane writes merge into the stored word.
        access(0, 2, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "w2_write20");
        access(0, 2, 1'b1, 32'h20, 32'h000000AA, 4'h1, 32'h0, 1'b0, "w2_lane0");
        access(0, 2, 1'b0, 32'h20, 32'h0, 4'h0, 32'h112233AA, 1'b0, "w2_read_lane0");
        access(0, 2, 1'b1, 32'h20, 32'h55660000, 4'hC, 32'h0, 1'b0, "w2_lane32");

        // ce_i held through DONE is ignored there; the following IDLE starts a new read.
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "b2b_c0");
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "b2b_c1");
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h556633AA, 1'b0, "b2b_done1");
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "b2b_c3");
        step(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "b2b_c4");
        step(0, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h556633AA, 1'b0, "b2b_done2");

        // Out-of-range: flagged once, no data, no write through aliasing index.
        access(0, 2, 1'b0, 32'h00004000, 32'h0, 4'h0, 32'h0, 1'b1, "w2_oor_read");
        step(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "w2_err_onecycle");
        access(0, 2, 1'b1, 32'h00004010, 32'h12345678, 4'hF, 32'h0, 1'b1, "w2_oor_write");
        access(0, 2, 1'b1, 32'h00001010, 32'h12345678, 4'hF, 32'h0, 1'b1, "w2_oor_edge_write");
        access(0, 2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "w2_unchanged10");

        // Top word in range; byte offset bits ignored.
        access(0, 2, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "w2_write_top");
        access(0, 2, 1'b0, 32'hFFF, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "w2_read_top_unaligned");

        // Reset in WAIT discards a write; the next access completes normally.
        access(0, 2, 1'b1, 32'h40, 32'h01020304, 4'hF, 32'h0, 1'b0, "w2_write40");
        step(0, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0, "rstw_c0");
        drive(0, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        rst = 1'b0;
        expect_out(0, 1'b0, 32'h0, 1'b0, "rstw_forced0");
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        expect_out(0, 1'b0, 32'h0, 1'b0, "rstw_idle");
        tick();
        step(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "rstw_idle2");
        access(0, 2, 1'b0, 32'h40, 32'h0, 4'h0, 32'h01020304, 1'b0, "rstw_read40");

        // W=3 abort when ce_i drops in WAIT.
        access(1, 3, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, "w3_write30");
        step(1, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0, "abort_c0");
        step(1, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0, "abort_c1");
        step(1, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0, "abort_drop");
        step(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "abort_idle");
        step(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "abort_idle2");
        access(1, 3, 1'b0, 32'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, "w3_read30");

        // W=0: single-cycle accesses, never stalls.
        step(2, 1'b1, 1'b1, 32'h8, 32'h5, 4'hF, 1'b0, 32'h0, 1'b0, "w0_write8");
        step(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h5, 1'b0, "w0_read8");
        step(2, 1'b1, 1'b1, 32'h8, 32'h00BB0000, 4'h4, 1'b0, 32'h0, 1'b0, "w0_lane2");
        step(2, 1'b1, 1'b0, 32'hA, 32'h0, 4'h0, 1'b0, 32'h00BB0005, 1'b0, "w0_read_merge");
        step(2, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, "w0_oor");
        step(2, 1'b1, 1'b1, 32'h4008, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1, "w0_oor_write");
        step(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h00BB0005, 1'b0, "w0_unchanged");
        step(2, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "w0_idle");

        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
